// File: rtl/topk_pkg.sv
// +--------------------------------------------------------------------+
// | topk_pkg: beat field offsets and FSM states for the top-k packer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package topk_pkg;

    localparam int BEAT_W       = 545;
    localparam int META_CNT_LSB = 529;
    localparam int META_SID_LSB = 513;
    localparam int TLAST_BIT    = 512;
    localparam int META_CNT_W   = 16;
    localparam int META_SID_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/topk_result_packer.sv
// +--------------------------------------------------------------------+
// | topk_result_packer: gathers 32-bit top-k words into 512-bit beats  |
// | with {count, session, tlast} metadata for the TCP sender.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module topk_result_packer
    import topk_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LANES  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cmd_TDATA,
    input  logic              cmd_TVALID,
    output logic              cmd_TREADY,
    input  logic [WORD_W-1:0] res_TDATA,
    input  logic              res_TVALID,
    output logic              res_TREADY,
    output logic [BEAT_W-1:0] pkt_tx_TDATA,
    output logic              pkt_tx_TVALID,
    input  logic              pkt_tx_TREADY,
    output logic [31:0]       beats_sent,
    output logic [31:0]       queries_done
);

    localparam int IDX_W  = $clog2(LANES);
    localparam int CNT_FW = IDX_W + 1;

    state_t r_state;
    state_t w_next;

    logic                    r_armed;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_remaining;
    logic [WORD_W*LANES-1:0] r_data;
    logic [META_SID_W-1:0]   r_sid;
    logic                    r_last;
    logic [CNT_FW-1:0]       r_cnt;
    logic [31:0]             r_beats;
    logic [31:0]             r_queries;

    logic w_cmd_fire;
    logic w_res_fire;
    logic w_pkt_fire;
    logic w_beat_done;
    logic w_cmd_zero;

    // Ready is held low for the reset cycle itself via r_armed, so it
    // only rises on the first edge after rst is released.
    assign cmd_TREADY    = (r_state == IDLE) && r_armed;
    assign res_TREADY    = (r_state == FILL);
    assign pkt_tx_TVALID = (r_state == EMIT);

    assign w_cmd_fire  = cmd_TVALID && cmd_TREADY;
    assign w_res_fire  = res_TVALID && res_TREADY;
    assign w_pkt_fire  = pkt_tx_TVALID && pkt_tx_TREADY;
    assign w_cmd_zero  = (cmd_TDATA[31:16] == 16'd0);
    assign w_beat_done = (r_idx == IDX_W'(LANES - 1)) || (r_remaining == CNT_W'(1));

    assign beats_sent   = r_beats;
    assign queries_done = r_queries;

    always_comb begin
        pkt_tx_TDATA                              = '0;
        pkt_tx_TDATA[WORD_W*LANES-1:0]            = r_data;
        pkt_tx_TDATA[TLAST_BIT]                   = r_last;
        pkt_tx_TDATA[META_SID_LSB +: META_SID_W]  = r_sid;
        pkt_tx_TDATA[META_CNT_LSB +: CNT_FW]      = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_next = w_cmd_zero ? EMIT : FILL;
                end
            end
            FILL: begin
                if (w_res_fire && w_beat_done) begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                if (w_pkt_fire) begin
                    w_next = r_last ? IDLE : FILL;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_armed     <= 1'b0;
            r_idx       <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_sid       <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_beats     <= '0;
            r_queries   <= '0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_sid       <= cmd_TDATA[15:0];
                        r_remaining <= CNT_W'(cmd_TDATA[31:16]);
                        r_idx       <= '0;
                        r_data      <= '0;
                        // An empty query still produces one terminating beat.
                        if (w_cmd_zero) begin
                            r_last <= 1'b1;
                            r_cnt  <= '0;
                        end
                    end
                end
                FILL: begin
                    if (w_res_fire) begin
                        r_data[r_idx*WORD_W +: WORD_W] <= res_TDATA;
                        r_idx       <= r_idx + IDX_W'(1);
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_beat_done) begin
                            r_last <= (r_remaining == CNT_W'(1));
                            r_cnt  <= {1'b0, r_idx} + CNT_FW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (w_pkt_fire) begin
                        r_beats <= r_beats + 32'd1;
                        if (r_last) begin
                            r_queries <= r_queries + 32'd1;
                        end else begin
                            r_data <= '0;
                            r_idx  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_topk_result_packer.sv
// +--------------------------------------------------------------------+
// | tb_topk_result_packer: directed self-checking bench for the packer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_topk_result_packer;

    logic          clk;
    logic          rst;
    logic [31:0]   cmd_TDATA;
    logic          cmd_TVALID;
    logic          cmd_TREADY;
    logic [31:0]   res_TDATA;
    logic          res_TVALID;
    logic          res_TREADY;
    logic [544:0]  pkt_tx_TDATA;
    logic          pkt_tx_TVALID;
    logic          pkt_tx_TREADY;
    logic [31:0]   beats_sent;
    logic [31:0]   queries_done;

    int            n_checks;
    int            n_errors;
    logic [544:0]  beats[$];
    logic          res_rdy_seen;

    topk_result_packer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_TDATA     (cmd_TDATA),
        .cmd_TVALID    (cmd_TVALID),
        .cmd_TREADY    (cmd_TREADY),
        .res_TDATA     (res_TDATA),
        .res_TVALID    (res_TVALID),
        .res_TREADY    (res_TREADY),
        .pkt_tx_TDATA  (pkt_tx_TDATA),
        .pkt_tx_TVALID (pkt_tx_TVALID),
        .pkt_tx_TREADY (pkt_tx_TREADY),
        .beats_sent    (beats_sent),
        .queries_done  (queries_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signals are stable between rising edges, so a beat seen valid and
    // ready here is the one accepted on the following edge.
    always @(negedge clk) begin
        if (rst && pkt_tx_TVALID && pkt_tx_TREADY) beats.push_back(pkt_tx_TDATA);
        if (res_TREADY) res_rdy_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [544:0] make_beat(input logic [15:0] sid, input logic last,
                                               input logic [31:0] first, input int nw);
        logic [544:0] b;
        b = '0;
        for (int i = 0; i < nw; i++) b[i*32 +: 32] = first + 32'(i);
        b[512]     = last;
        b[528:513] = sid;
        b[544:529] = 16'(nw);
        return b;
    endfunction

    task automatic send_cmd(input logic [15:0] sid, input logic [15:0] n);
        int k;
        k = 0;
        cmd_TDATA  = {n, sid};
        cmd_TVALID = 1'b1;
        while (!cmd_TREADY && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("cmd_handshake", cmd_TREADY, 1);
        @(posedge clk); #1;
        cmd_TVALID = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input int max_gap);
        int k;
        k = 0;
        res_TDATA  = w;
        res_TVALID = 1'b1;
        while (!res_TREADY && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("res_handshake", res_TREADY, 1);
        @(posedge clk); #1;
        res_TVALID = 1'b0;
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k;
        k = 0;
        while (beats.size() < n && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, beats.size(), n);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [544:0] snap;
        logic         stable;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        cmd_TDATA     = '0;
        cmd_TVALID    = 1'b0;
        res_TDATA     = '0;
        res_TVALID    = 1'b0;
        pkt_tx_TREADY = 1'b1;
        res_rdy_seen  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_TREADY, 0);
        check("rst_res_ready", res_TREADY, 0);
        check("rst_valid", pkt_tx_TVALID, 0);
        check("rst_tdata", pkt_tx_TDATA, 0);
        check("rst_beats", beats_sent, 0);
        check("rst_queries", queries_done, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", cmd_TREADY, 1);

        // Single full beat.
        beats.delete();
        send_cmd(16'h0007, 16'd16);
        for (int i = 1; i <= 16; i++) push_word(32'(i), 0);
        check("latency_valid", pkt_tx_TVALID, 1);
        wait_beats("t1_nbeats", 1);
        check("t1_beat", beats[0], make_beat(16'h0007, 1'b1, 32'd1, 16));
        check("t1_queries", queries_done, 1);
        check("t1_beats", beats_sent, 1);

        // Two beats, partial tail.
        beats.delete();
        send_cmd(16'h0011, 16'd20);
        for (int i = 1; i <= 20; i++) push_word(32'(i), 0);
        wait_beats("t2_nbeats", 2);
        check("t2_beat0", beats[0], make_beat(16'h0011, 1'b0, 32'd1, 16));
        check("t2_beat1", beats[1], make_beat(16'h0011, 1'b1, 32'd17, 4));
        check("t2_beats", beats_sent, 3);
        check("t2_queries", queries_done, 2);

        // Empty query, with a stray word waiting upstream.
        beats.delete();
        res_rdy_seen = 1'b0;
        res_TDATA    = 32'hDEAD_BEEF;
        res_TVALID   = 1'b1;
        send_cmd(16'h0022, 16'd0);
        wait_beats("t3_nbeats", 1);
        res_TVALID = 1'b0;
        check("t3_beat", beats[0], make_beat(16'h0022, 1'b1, 32'd0, 0));
        check("t3_no_res_ready", res_rdy_seen, 0);
        check("t3_queries", queries_done, 3);

        // Backpressure on the first beat of a two-beat query.
        beats.delete();
        pkt_tx_TREADY = 1'b0;
        fork
            begin
                send_cmd(16'h0033, 16'd20);
                for (int i = 0; i < 20; i++) push_word(32'h100 + 32'(i), 0);
            end
            begin
                int k;
                k = 0;
                while (!pkt_tx_TVALID && k < 500) begin
                    @(posedge clk); #1;
                    k++;
                end
                check("bp_valid_seen", pkt_tx_TVALID, 1);
                snap   = pkt_tx_TDATA;
                stable = 1'b1;
                repeat (50) begin
                    @(posedge clk); #1;
                    if (pkt_tx_TDATA !== snap || pkt_tx_TVALID !== 1'b1 || res_TREADY !== 1'b0)
                        stable = 1'b0;
                end
                check("bp_stable", stable, 1);
                pkt_tx_TREADY = 1'b1;
            end
        join
        wait_beats("bp_nbeats", 2);
        check("bp_beat0", beats[0], make_beat(16'h0033, 1'b0, 32'h100, 16));
        check("bp_beat1", beats[1], make_beat(16'h0033, 1'b1, 32'h110, 4));
        check("bp_beats", beats_sent, 6);

        // Back-to-back commands with random source gaps.
        beats.delete();
        fork
            begin
                send_cmd(16'h0001, 16'd3);
                send_cmd(16'h0002, 16'd17);
            end
            begin
                for (int i = 0; i < 3; i++)  push_word(32'h301 + 32'(i), 3);
                for (int i = 0; i < 17; i++) push_word(32'h401 + 32'(i), 3);
            end
        join
        wait_beats("b2b_nbeats", 3);
        check("b2b_beat0", beats[0], make_beat(16'h0001, 1'b1, 32'h301, 3));
        check("b2b_beat1", beats[1], make_beat(16'h0002, 1'b0, 32'h401, 16));
        check("b2b_beat2", beats[2], make_beat(16'h0002, 1'b1, 32'h411, 1));
        check("b2b_queries", queries_done, 6);

        // Reset in the middle of a query.
        beats.delete();
        send_cmd(16'h0009, 16'd16);
        for (int i = 0; i < 5; i++) push_word(32'hF00 + 32'(i), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_cmd_ready", cmd_TREADY, 0);
        check("mid_rst_res_ready", res_TREADY, 0);
        check("mid_rst_valid", pkt_tx_TVALID, 0);
        check("mid_rst_tdata", pkt_tx_TDATA, 0);
        check("mid_rst_beats", beats_sent, 0);
        check("mid_rst_queries", queries_done, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        send_cmd(16'h00AB, 16'd2);
        push_word(32'h501, 0);
        push_word(32'h502, 0);
        wait_beats("post_rst_nbeats", 1);
        check("post_rst_beat", beats[0], make_beat(16'h00AB, 1'b1, 32'h501, 2));
        check("post_rst_beats", beats_sent, 1);
        check("post_rst_queries", queries_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
